mod_n_up_down_counter: RTL and testbench

MOD_N_UP_DOWN_COUNTER -- requirements
Module: mod_n_up_down_counter

---
 rtl/counter_pkg.sv | 10 +
 rtl/count_prescaler.sv | 34 +++
 rtl/mod_n_up_down_counter.sv | 85 ++++++++
 tb/tb_mod_n_up_down_counter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the counter family: direction and bound-handling values
// driven onto the mode and sat inputs.
package counter_pkg;

    localparam logic COUNT_UP   = 1'b1;
    localparam logic COUNT_DOWN = 1'b0;
    localparam logic MODE_WRAP  = 1'b0;
    localparam logic MODE_SAT   = 1'b1;

endpackage : counter_pkg

// File: rtl/count_prescaler.sv
// Tick generator: raises tick on every PRESCALE-th cycle that has en=1.
// clr restarts the count; tick is combinational so the parent steps on that same edge.
module count_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("count_prescaler: PRESCALE must be >= 1");
    end

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clock) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule : count_prescaler

// File: rtl/mod_n_up_down_counter.sv
// Modulo-N up/down counter with load, saturate-or-wrap bounds, a wrap pulse and
// a sticky overflow flag. Define MOD_COUNTER_PRESCALE_EN to add an input prescaler.
module mod_n_up_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 10
`ifdef MOD_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] dout,
    output logic             wrap,
    output logic             ovf
);

    // Compare constants carry one extra bit so MODULUS = 2**WIDTH stays representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   TOP_EXT = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("mod_n_up_down_counter: MODULUS must lie in 2..2**WIDTH");
    end

    logic             step;
    logic             boundary;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] next_dout;

`ifdef MOD_COUNTER_PRESCALE_EN
    count_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clock(clock),
        .rst  (rst),
        .clr  (load),
        .en   (en),
        .tick (step)
    );
`else
    assign step = en;
`endif

    assign load_val = ({1'b0, din} >= MOD_EXT) ? TOP : din;
    assign boundary = step && !load &&
                      ((mode == COUNT_UP) ? ({1'b0, dout} >= TOP_EXT) : (dout == '0));

    always_comb begin
        // NOTE: default first so every path assigns next_dout and no latch is inferred.
        next_dout = dout;
        if (load) begin
            next_dout = load_val;
        end else if (boundary) begin
            if (sat == MODE_WRAP) begin
                next_dout = (mode == COUNT_UP) ? '0 : TOP;
            end
        end else if (step) begin
            next_dout = (mode == COUNT_UP) ? dout + WIDTH'(1) : dout - WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            dout <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            dout <= next_dout;
            wrap <= boundary;
            ovf  <= boundary | (ovf & ~clr_ovf);
        end
    end

endmodule : mod_n_up_down_counter

// File: tb/tb_mod_n_up_down_counter.sv
// Self-checking bench for mod_n_up_down_counter (WIDTH=4, MODULUS=10): directed
// literal checks plus an arithmetic reference model compared on every falling edge.
module tb_mod_n_up_down_counter;

    localparam int WIDTH    = 4;
    localparam int MODULUS  = 10;
`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int PRESCALE = 4;
`endif

    logic             clock = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic             sat = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             clr_ovf = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             wrap;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    mod_n_up_down_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
`ifdef MOD_COUNTER_PRESCALE_EN
        ,
        .PRESCALE(PRESCALE)
`endif
    ) dut (
        .clock  (clock),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .sat    (sat),
        .load   (load),
        .din    (din),
        .clr_ovf(clr_ovf),
        .dout   (dout),
        .wrap   (wrap),
        .ovf    (ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the counting rules.
    int m_dout, m_pre, nxt;
    bit m_wrap, m_ovf, m_valid = 1'b0, stepping, ev;

    always @(posedge clock) begin
        if (rst) begin
            m_dout = 0; m_wrap = 0; m_ovf = 0; m_pre = 0; m_valid = 1;
        end else if (load) begin
            m_dout = (int'(din) >= MODULUS) ? MODULUS - 1 : int'(din);
            m_wrap = 0;
            m_ovf  = m_ovf && !clr_ovf;
            m_pre  = 0;
        end else begin
            stepping = en;
`ifdef MOD_COUNTER_PRESCALE_EN
            if (en) begin
                m_pre++;
                stepping = (m_pre == PRESCALE);
                if (stepping) m_pre = 0;
            end
`endif
            ev = 0;
            if (stepping) begin
                nxt = m_dout + (mode ? 1 : -1);
                ev  = (nxt < 0) || (nxt >= MODULUS);
                if (!ev) m_dout = nxt;
                else if (!sat) m_dout = (nxt + MODULUS) % MODULUS;
            end
            m_wrap = ev;
            m_ovf  = ev || (m_ovf && !clr_ovf);
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("model_dout", 32'(dout), 32'(m_dout));
            check("model_wrap", 32'(wrap), 32'(m_wrap));
            check("model_ovf", 32'(ovf), 32'(m_ovf));
            check("range", 32'(int'(dout) < MODULUS), 32'd1);
        end
    end

    // Inputs change 1 time unit after the rising edge, far from either edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string name, input int d, input bit w, input bit o);
        check({name, "_dout"}, 32'(dout), 32'(d));
        check({name, "_wrap"}, 32'(wrap), 32'(w));
        check({name, "_ovf"}, 32'(ovf), 32'(o));
    endtask

    task automatic do_load(input int v);
        load = 1; en = 0; din = WIDTH'(v);
        cyc();
        load = 0;
    endtask

    int up_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int pre_seq [8] = '{0, 0, 0, 1, 1, 1, 1, 2};

    initial begin
        rst = 1;
        cyc(); cyc();
        rst = 0;
        expect_out("reset", 0, 0, 0);

`ifdef MOD_COUNTER_PRESCALE_EN
        en = 1; mode = 1; sat = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check($sformatf("pre_dout_%0d", i), 32'(dout), 32'(pre_seq[i]));
        end
        en = 0;
`else
        // Wrapping up-count through the boundary.
        en = 1; mode = 1; sat = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            expect_out($sformatf("up_%0d", i), up_seq[i], up_seq[i] == 0, i >= 9);
        end

        // Saturating down-count at zero.
        do_load(0);
        expect_out("load0", 0, 0, 1);
        en = 1; mode = 0; sat = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_out($sformatf("satdn_%0d", i), 0, 1, 1);
        end
        en = 0; clr_ovf = 1;
        cyc();
        clr_ovf = 0;
        expect_out("clr_ovf", 0, 0, 0);

        // Load clamps and beats a same-cycle step.
        do_load(13);
        expect_out("load13", 9, 0, 0);
        load = 1; en = 1; mode = 1; din = 3;
        cyc();
        load = 0; en = 0;
        expect_out("load_vs_step", 3, 0, 0);

        // Boundary event together with clr_ovf keeps ovf set.
        do_load(9);
        en = 1; mode = 1; sat = 0; clr_ovf = 1;
        cyc();
        en = 0; clr_ovf = 0;
        expect_out("event_and_clr", 0, 1, 1);

        // Saturating up at the top; wrapping down from zero.
        do_load(9);
        en = 1; mode = 1; sat = 1;
        cyc();
        en = 0;
        expect_out("satup", 9, 1, 1);
        do_load(0);
        en = 1; mode = 0; sat = 0;
        cyc();
        en = 0;
        expect_out("wrapdn", 9, 1, 1);

        // Reset overrides a same-cycle load; counting resumes immediately.
        do_load(7);
        expect_out("pre_rst", 7, 0, 1);
        rst = 1; load = 1; din = 5; en = 1; clr_ovf = 0;
        cyc();
        rst = 0; load = 0; mode = 1; sat = 0;
        expect_out("rst_over_load", 0, 0, 0);
        cyc();
        en = 0;
        expect_out("resume", 1, 0, 0);
`endif

        // Mixed-stimulus tail checked by the model alone.
        for (int i = 0; i < 300; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            load    = ($urandom_range(0, 7) == 0);
            en      = ($urandom_range(0, 3) != 0);
            mode    = 1'($urandom_range(0, 1));
            sat     = 1'($urandom_range(0, 1));
            clr_ovf = ($urandom_range(0, 3) == 0);
            din     = WIDTH'($urandom_range(0, 15));
            cyc();
        end
        rst = 0; load = 0; en = 0; clr_ovf = 0;
        cyc();
        @(negedge clock);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mod_n_up_down_counter
